// File: rtl/perf_counter_ctrl_if.sv
// perf_counter_ctrl_if: event, config and snapshot-stream bundle.
// master drives events/config/ready; slave is the counter controller.
interface perf_counter_ctrl_if #(
  parameter int NUM_EVENTS = 32,
  parameter int NUM_CNT    = 8
);
  localparam int EW = $clog2(NUM_EVENTS);
  localparam int CW = $clog2(NUM_CNT);

  logic [NUM_EVENTS-1:0] evt;
  logic                  cfg_we;
  logic [CW-1:0]         cfg_idx;
  logic [EW-1:0]         cfg_sel;
  logic                  cfg_en;
  logic                  dump_req;
  logic                  dump_busy;
  logic                  out_valid;
  logic                  out_ready;
  logic [CW-1:0]         out_idx;
  logic [31:0]           out_data;
  logic                  out_ovf;
  logic                  dump_done;

  modport master (
    output evt,
    output cfg_we,
    output cfg_idx,
    output cfg_sel,
    output cfg_en,
    output dump_req,
    output out_ready,
    input  dump_busy,
    input  out_valid,
    input  out_idx,
    input  out_data,
    input  out_ovf,
    input  dump_done
  );

  modport slave (
    input  evt,
    input  cfg_we,
    input  cfg_idx,
    input  cfg_sel,
    input  cfg_en,
    input  dump_req,
    input  out_ready,
    output dump_busy,
    output out_valid,
    output out_idx,
    output out_data,
    output out_ovf,
    output dump_done
  );
endinterface

// File: rtl/perf_counter_ctrl.sv
// perf_counter_ctrl: shared event counters with snapshot streaming.
// Option PERF_CLEAR_ON_READ_EN: a snapshot restarts the live counters.
module perf_counter_ctrl #(
  parameter int NUM_EVENTS = 32,
  parameter int NUM_CNT    = 8
) (
  input  logic               clk,
  input  logic               rst,
  perf_counter_ctrl_if.slave bus
);
  localparam int EW = $clog2(NUM_EVENTS);
  localparam int CW = $clog2(NUM_CNT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                   r_state;
  state_t                   w_state_nxt;
  logic [CW-1:0]            r_ptr;
  logic [CW-1:0]            w_ptr_nxt;

  logic [EW-1:0]            r_sel [NUM_CNT];
  logic [NUM_CNT-1:0]       r_en;
  logic [NUM_CNT-1:0]       r_ovf;
  logic [NUM_CNT-1:0][31:0] r_cnt;
  logic [NUM_CNT-1:0]       r_sovf;
  logic [NUM_CNT-1:0][31:0] r_scnt;

  logic [NUM_CNT-1:0]       w_hit;
  logic [NUM_CNT-1:0]       w_wr;
  logic [NUM_CNT-1:0]       w_max;
  logic                     w_snap;
  logic                     w_last;

  assign w_snap = (r_state == S_IDLE) && bus.dump_req;
  assign w_last = (r_ptr == CW'(NUM_CNT - 1));

  always_comb begin
    w_hit = '0;
    w_wr  = '0;
    w_max = '0;
    for (int i = 0; i < NUM_CNT; i++) begin
      w_hit[i] = r_en[i] && bus.evt[r_sel[i]];
      w_wr[i]  = bus.cfg_we && (int'(bus.cfg_idx) == i);
      w_max[i] = &r_cnt[i];
    end
  end

  // Config write wins over any increment or snapshot restart.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_en  <= '0;
      r_ovf <= '0;
      r_cnt <= '0;
      for (int i = 0; i < NUM_CNT; i++) begin
        r_sel[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CNT; i++) begin
        if (w_wr[i]) begin
          r_sel[i] <= bus.cfg_sel;
          r_en[i]  <= bus.cfg_en;
          r_cnt[i] <= '0;
          r_ovf[i] <= 1'b0;
        end
`ifdef PERF_CLEAR_ON_READ_EN
        else if (w_snap) begin
          r_cnt[i] <= {31'd0, w_hit[i]};
          r_ovf[i] <= w_hit[i] && w_max[i];
        end
`endif
        else if (w_hit[i]) begin
          r_cnt[i] <= r_cnt[i] + 32'd1;
          if (w_max[i]) begin
            r_ovf[i] <= 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_scnt <= '0;
      r_sovf <= '0;
    end else if (w_snap) begin
      r_scnt <= r_cnt;
      r_sovf <= r_ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    bus.dump_busy = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_idx   = '0;
    bus.out_data  = '0;
    bus.out_ovf   = 1'b0;
    bus.dump_done = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.dump_req) begin
          w_state_nxt = S_SEND;
          w_ptr_nxt   = '0;
        end
      end
      S_SEND: begin
        bus.dump_busy = 1'b1;
        bus.out_valid = 1'b1;
        bus.out_idx   = r_ptr;
        bus.out_data  = r_scnt[r_ptr];
        bus.out_ovf   = r_sovf[r_ptr];
        if (bus.out_ready) begin
          if (w_last) begin
            w_state_nxt = S_DONE;
          end else begin
            w_ptr_nxt = r_ptr + CW'(1);
          end
        end
      end
      S_DONE: begin
        bus.dump_busy = 1'b1;
        bus.dump_done = 1'b1;
        w_state_nxt   = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end
endmodule

// File: tb/tb_perf_counter_ctrl.sv
// tb_perf_counter_ctrl: directed + random stimulus against a
// queue-based snapshot model of the counter controller.
module tb_perf_counter_ctrl;
  localparam int NE = 32;
  localparam int NC = 8;

`ifdef PERF_CLEAR_ON_READ_EN
  localparam bit COR = 1'b1;
`else
  localparam bit COR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  perf_counter_ctrl_if #(.NUM_EVENTS(NE), .NUM_CNT(NC)) bus ();

  perf_counter_ctrl #(.NUM_EVENTS(NE), .NUM_CNT(NC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int          idx;
    logic [31:0] d;
    logic        o;
  } ent_t;

  ent_t        m_q[$];
  logic [31:0] m_cnt [NC];
  logic        m_ovf [NC];
  int          m_sel [NC];
  logic        m_en  [NC];
  logic        m_done;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int t_req   = 0;
  int t_done  = 0;
  int n_done  = 0;

  logic [31:0] g_data [NC];
  logic        g_ovf  [NC];
  int          g_order[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic bit m_busy();
    return (m_q.size() != 0) || m_done;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < NC; i++) begin
      m_cnt[i] = '0;
      m_ovf[i] = 1'b0;
      m_sel[i] = 0;
      m_en[i]  = 1'b0;
    end
    m_q.delete();
    m_done = 1'b0;
  endfunction

  // Check outputs for this cycle, then advance the model across the edge.
  task automatic step();
    bit   busy;
    bit   ndone;
    bit   snap;
    bit   hit;
    ent_t e;
    busy = m_busy();
    chk("busy", bus.dump_busy, busy);
    chk("valid", bus.out_valid, m_q.size() != 0);
    chk("done", bus.dump_done, m_done);
    if (m_q.size() != 0) begin
      chk("idx", bus.out_idx, m_q[0].idx);
      chk("data", bus.out_data, m_q[0].d);
      chk("ovf", bus.out_ovf, m_q[0].o);
    end
    if (bus.dump_done === 1'b1) begin
      n_done++;
      t_done = cyc;
    end
    ndone = 1'b0;
    if (m_q.size() != 0 && bus.out_ready) begin
      g_data[m_q[0].idx] = bus.out_data;
      g_ovf[m_q[0].idx]  = bus.out_ovf;
      g_order.push_back(int'(bus.out_idx));
      void'(m_q.pop_front());
      ndone = (m_q.size() == 0);
    end
    snap = 1'b0;
    if (!busy && bus.dump_req) begin
      for (int i = 0; i < NC; i++) begin
        e.idx = i;
        e.d   = m_cnt[i];
        e.o   = m_ovf[i];
        m_q.push_back(e);
      end
      t_req = cyc;
      snap  = 1'b1;
    end
    m_done = ndone;
    for (int i = 0; i < NC; i++) begin
      hit = m_en[i] && bus.evt[m_sel[i]];
      if (bus.cfg_we && int'(bus.cfg_idx) == i) begin
        m_sel[i] = int'(bus.cfg_sel);
        m_en[i]  = bus.cfg_en;
        m_cnt[i] = '0;
        m_ovf[i] = 1'b0;
      end else if (snap && COR) begin
        m_ovf[i] = hit && (m_cnt[i] == 32'hFFFF_FFFF);
        m_cnt[i] = hit ? 32'd1 : 32'd0;
      end else if (hit) begin
        if (m_cnt[i] == 32'hFFFF_FFFF) m_ovf[i] = 1'b1;
        m_cnt[i] = m_cnt[i] + 32'd1;
      end
    end
    if (rst) m_reset();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic cfg(input int idx, input int sel, input bit en);
    bus.cfg_we  = 1'b1;
    bus.cfg_idx = 3'(idx);
    bus.cfg_sel = 5'(sel);
    bus.cfg_en  = en;
    step();
    bus.cfg_we  = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // mode 0: ready high; 1: ready 1,0,0,1; 2: evt[7] for 5 SEND cycles
  task automatic do_dump(input int mode, input bit poke);
    int k;
    int pat[4] = '{1, 0, 0, 1};
    n_done = 0;
    g_order.delete();
    for (int i = 0; i < NC; i++) begin
      g_data[i] = 'x;
      g_ovf[i]  = 1'bx;
    end
    bus.out_ready = 1'b1;
    bus.dump_req  = 1'b1;
    step();
    bus.dump_req = 1'b0;
    k = 0;
    while (m_busy() && k < 200) begin
      bus.out_ready = (mode == 1) ? (pat[k % 4] != 0) : 1'b1;
      bus.dump_req  = poke && (k == 2);
      if (mode == 2) bus.evt = (k < 5) ? (32'd1 << 7) : '0;
      step();
      k++;
    end
    bus.dump_req  = 1'b0;
    bus.out_ready = 1'b1;
    if (mode == 2) bus.evt = '0;
    chk("drain", bus.dump_busy, 1'b0);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "simulation did not terminate");
  end

  initial begin
    bus.evt       = '0;
    bus.cfg_we    = 1'b0;
    bus.cfg_idx   = '0;
    bus.cfg_sel   = '0;
    bus.cfg_en    = 1'b0;
    bus.dump_req  = 1'b0;
    bus.out_ready = 1'b1;
    m_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;

    chk("rst_busy", bus.dump_busy, 1'b0);
    chk("rst_valid", bus.out_valid, 1'b0);
    chk("rst_idx", bus.out_idx, 3'd0);
    chk("rst_data", bus.out_data, 32'd0);
    chk("rst_ovf", bus.out_ovf, 1'b0);
    chk("rst_done", bus.dump_done, 1'b0);

    // Route: counter 2 follows evt[5] only
    cfg(2, 5, 1'b1);
    repeat (10) begin
      bus.evt = 32'd1 << 5;
      step();
    end
    repeat (3) begin
      bus.evt = 32'd1 << 4;
      step();
    end
    bus.evt = '0;
    do_dump(0, 1'b0);
    for (int i = 0; i < NC; i++) begin
      chk("route_data", g_data[i], (i == 2) ? 32'd10 : 32'd0);
      chk("route_ovf", g_ovf[i], 1'b0);
    end
    chk("route_lat", t_done - t_req, NC + 1);
    chk("route_ndone", n_done, 1);

    // Wrap from preloaded 0xFFFFFFFE
    do_reset();
    cfg(0, 0, 1'b1);
    force dut.r_cnt[0] = 32'hFFFF_FFFE;
    #1;
    release dut.r_cnt[0];
    m_cnt[0] = 32'hFFFF_FFFE;
    bus.evt = 32'd1;
    repeat (5) step();
    bus.evt = '0;
    do_dump(0, 1'b0);
    chk("wrap_data", g_data[0], 32'd3);
    chk("wrap_ovf", g_ovf[0], 1'b1);

    // Collision: config write beats same-cycle event; extra req ignored
    do_reset();
    cfg(1, 9, 1'b1);
    bus.evt = 32'd1 << 9;
    repeat (3) step();
    cfg(1, 9, 1'b1);
    bus.evt = '0;
    do_dump(0, 1'b1);
    chk("coll_data", g_data[1], 32'd0);
    chk("coll_ndone", n_done, 1);
    repeat (3) step();

    // Backpressure with ready pattern 1,0,0,1
    do_reset();
    for (int i = 0; i < NC; i++) cfg(i, i * 3, 1'b1);
    repeat (20) begin
      bus.evt = $urandom;
      step();
    end
    bus.evt = '0;
    do_dump(1, 1'b0);
    chk("bp_count", g_order.size(), NC);
    for (int i = 0; i < g_order.size(); i++) begin
      chk("bp_order", g_order[i], i);
    end
    chk("bp_ndone", n_done, 1);

    // Snapshot isolation on counter 3
    do_reset();
    cfg(3, 7, 1'b1);
    repeat (4) begin
      bus.evt = 32'd1 << 7;
      step();
    end
    bus.evt = '0;
    do_dump(2, 1'b0);
    chk("iso_first", g_data[3], 32'd4);
    do_dump(0, 1'b0);
    chk("iso_second", g_data[3], COR ? 32'd5 : 32'd9);

    // Reset while entry 4 is on the stream
    do_reset();
    for (int i = 0; i < NC; i++) cfg(i, $urandom_range(0, NE - 1), 1'b1);
    repeat (10) begin
      bus.evt = $urandom;
      step();
    end
    bus.evt       = '0;
    bus.out_ready = 1'b1;
    bus.dump_req  = 1'b1;
    step();
    bus.dump_req = 1'b0;
    repeat (4) step();
    chk("mid_idx", bus.out_idx, 3'd4);
    n_done = 0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_valid", bus.out_valid, 1'b0);
    chk("mid_busy", bus.dump_busy, 1'b0);
    chk("mid_nodone", n_done, 0);
    do_dump(0, 1'b0);
    for (int i = 0; i < NC; i++) chk("mid_zero", g_data[i], 32'd0);

    // Random traffic
    do_reset();
    repeat (600) begin
      bus.evt       = $urandom;
      bus.cfg_we    = ($urandom_range(0, 9) == 0);
      bus.cfg_idx   = 3'($urandom_range(0, NC - 1));
      bus.cfg_sel   = 5'($urandom_range(0, NE - 1));
      bus.cfg_en    = 1'($urandom_range(0, 1));
      bus.dump_req  = ($urandom_range(0, 19) == 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      rst           = ($urandom_range(0, 199) == 0);
      step();
    end
    bus.evt       = '0;
    bus.cfg_we    = 1'b0;
    bus.dump_req  = 1'b0;
    bus.out_ready = 1'b1;
    rst           = 1'b0;
    repeat (20) step();
    chk("rand_idle", bus.dump_busy, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/perf_counter_ctrl.md
# perf_counter_ctrl

Shared performance-counter controller. Maps many single-cycle event strobes onto a small bank of programmable 32-bit counters and serialises counter snapshots to a log/difftest sink over a valid/ready stream. It sits beside the core's event sources, so there is no longer one dedicated counter per event.

## Interface
- NUM_EVENTS, 32: number of event strobe inputs.
- NUM_CNT, 8: number of hardware counters.
- EW, $clog2(NUM_EVENTS): event-select width.
- CW, $clog2(NUM_CNT): counter-index width.
- clk  in  1  clock; all logic on posedge.
- rst  in  1  reset, synchronous, active-high.
- evt  in  NUM_EVENTS  event strobes; bit e asserted means one occurrence this cycle.
- cfg_we  in  1  config write strobe.
- cfg_idx  in  CW  counter to configure.
- cfg_sel  in  EW  event routed to that counter.
- cfg_en  in  1  counter enable.
- dump_req  in  1  request a snapshot-and-stream; sampled only in IDLE.
- dump_busy  out  1  high while not in IDLE.
- out_valid  out  1  stream entry valid.
- out_ready  in  1  sink accepts the entry.
- out_idx  out  CW  counter index of the entry.
- out_data  out  32  snapshot value.
- out_ovf  out  1  snapshot sticky-overflow bit.
- dump_done  out  1  one-cycle pulse after the last entry is accepted.

## Operation
- Per counter i: sel[i] (EW), en[i], cnt[i] (32), ovf[i] (sticky).
- Reset: sel=0, en=0, cnt=0, ovf=0, FSM=IDLE. Reset outputs: dump_busy=0, out_valid=0, out_idx=0, out_data=0, out_ovf=0, dump_done=0.
- Counting: each cycle, if en[i] && evt[sel[i]], then cnt[i] <= cnt[i]+1, wrapping modulo 2^32. A wrap from 0xFFFFFFFF sets ovf[i]. The ovf bit clears only on reset or a config write to counter i.
- cfg_idx >= NUM_CNT: the write is ignored.
- Config write to i: sel[i]<=cfg_sel, en[i]<=cfg_en, cnt[i]<=0, ovf[i]<=0. The write has priority over a same-cycle increment, so the increment is lost. Config writes are accepted in every FSM state and affect live counters only.
- FSM states:
  - IDLE: dump_req=1 copies every cnt/ovf into shadow registers (pre-increment values of this cycle) -> SEND, ptr=0.
  - SEND: out_valid=1, out_idx=ptr, out_data=shadow_cnt[ptr], out_ovf=shadow_ovf[ptr]. On out_valid&&out_ready: if ptr==NUM_CNT-1 -> DONE, else ptr+1.
  - DONE: dump_done=1 for one cycle -> IDLE.
- dump_req outside IDLE is ignored (no queuing).
- Outputs stay stable while out_valid && !out_ready. Live counting continues throughout a dump.

## Timing
- Increment is visible on cnt the cycle after the strobe.
- dump_req at cycle T: first out_valid at T+1.
- With out_ready held high, entries appear at T+1..T+NUM_CNT, dump_done at T+NUM_CNT+1, and the next dump_req is accepted at T+NUM_CNT+2.
- Reset asserted mid-dump: the next cycle is IDLE with all outputs at their reset values. The partial stream is abandoned and no dump_done is emitted.

## Configuration
- PERF_CLEAR_ON_READ_EN defined: in the snapshot cycle, each live cnt[i] is loaded with 1 if it increments that cycle, else 0. Its ovf[i] is cleared, unless cnt[i] wraps in that same cycle, in which case ovf[i] is set. A config write in that cycle still has priority.
- PERF_CLEAR_ON_READ_EN undefined: the snapshot leaves live counters untouched.

## Test plan
- Route: cfg counter 2 to sel=5, en=1; pulse evt[5] for 10 cycles, evt[4] for 3 cycles; dump with out_ready=1 -> entry idx 2 has data=10, ovf=0; all other entries are 0; dump_done at T+NUM_CNT+1.
- Wrap: counter 0 on evt[0]; hold evt[0] for 2^32+3 cycles, or force cnt[0]=0xFFFFFFFE and pulse 5 times -> data=3, ovf=1.
- Backpressure: dump with out_ready toggling 1,0,0,1 -> out_idx/out_data stable while stalled; 8 entries in order 0..7; exactly one dump_done.
- Collision: cfg write to counter 1 in the same cycle as its event -> cnt[1]=0 next cycle. A dump_req during SEND is ignored: no second stream.
- Snapshot isolation: events on counter 3 during SEND -> streamed value equals the count at T. With PERF_CLEAR_ON_READ_EN, a second dump shows only the post-T events; without it, the second dump shows the cumulative total.
- Reset mid-dump at entry 4 -> next cycle out_valid=0, dump_busy=0, all counters 0; a new dump streams all zeros.
